// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory arbiter
package mem_arb_pkg;
  localparam int BLOCK_WORDS = 8;
  localparam int OFFSET_BITS = 4;
  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;
  typedef enum logic [1:0] {IDLE, IFILL, DFILL, DWRITE} state_t;
endpackage

// File: rtl/mem_arbiter_word_counter.sv
// word_counter_3b: 3-bit word counter with enable and synchronous clear, wraps 7->0
module word_counter_3b (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  output logic [2:0] cnt
);
  // clear wins over increment so a block end always restarts at word 0
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 3'd1;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between I fill, D fill and D write-through
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int BLOCK_WORDS = 8,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_miss,
  input  logic [ADDR_W-1:0] i_miss_addr,
  output logic              i_busy,
  output logic              i_data_valid,
  output logic [2:0]        i_word_idx,
  output logic              i_fill_done,
  input  logic              d_miss,
  input  logic [ADDR_W-1:0] d_miss_addr,
  output logic              d_busy,
  output logic              d_data_valid,
  output logic [2:0]        d_word_idx,
  output logic              d_fill_done,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [ADDR_W-1:0] d_wr_data,
  output logic              d_wr_ack,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] mem_data_in,
  input  logic              mem_data_valid
);
  state_t state, state_nxt;
  logic last_miss, issued, fill, issuing, recv, last_word, pick_d;
  logic [ADDR_W-OFFSET_BITS-1:0] base;
  logic [ADDR_W-1:0] wr_addr, wr_data;
  logic [2:0] issue_cnt, recv_cnt;
  logic unused;

  assign unused = ^{i_miss_addr[OFFSET_BITS-1:0], d_miss_addr[OFFSET_BITS-1:0]};
  assign fill = (state == IFILL) || (state == DFILL);
  assign issuing = fill && !issued;
  assign recv = fill && mem_data_valid;
  assign last_word = recv && (recv_cnt == 3'(BLOCK_WORDS - 1));
  assign pick_d = d_miss && (!i_miss || last_miss == REQ_I);

  word_counter_3b u_issue (.clk(clk), .rst_n(rst_n), .en(issuing), .clr(last_word), .cnt(issue_cnt));
  word_counter_3b u_recv (.clk(clk), .rst_n(rst_n), .en(recv), .clr(last_word), .cnt(recv_cnt));

  // next state: writes beat misses, contested misses alternate via last_miss
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:         state_nxt = d_wr_req ? DWRITE : pick_d ? DFILL : i_miss ? IFILL : IDLE;
      IFILL, DFILL: state_nxt = last_word ? IDLE : state;
      default:      state_nxt = IDLE;
    endcase
  end

  // state, grant latches and issue-phase completion flag
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      last_miss <= REQ_I;
      issued <= 1'b0;
      base <= '0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      state <= state_nxt;
      issued <= last_word ? 1'b0 : (issuing && issue_cnt == 3'(BLOCK_WORDS - 1)) ? 1'b1 : issued;
      if (state == IDLE && state_nxt == DWRITE) begin
        wr_addr <= d_wr_addr;
        wr_data <= d_wr_data;
      end
      if (state == IDLE && state_nxt == DFILL) begin
        base <= d_miss_addr[ADDR_W-1:OFFSET_BITS];
        last_miss <= REQ_D;
      end
      if (state == IDLE && state_nxt == IFILL) begin
        base <= i_miss_addr[ADDR_W-1:OFFSET_BITS];
        last_miss <= REQ_I;
      end
    end

  // outputs decode only from registered state, so requests never reach mem_* combinationally
  always_comb begin
    mem_en = issuing || state == DWRITE;
    mem_wr = state == DWRITE;
    mem_addr = issuing ? {base, issue_cnt, 1'b0} : (state == DWRITE) ? wr_addr : '0;
    mem_data_in = (state == DWRITE) ? wr_data : '0;
    d_wr_ack = state == DWRITE;
    i_busy = state == IFILL;
    d_busy = state == DFILL || state == DWRITE;
    i_data_valid = state == IFILL && mem_data_valid;
    d_data_valid = state == DFILL && mem_data_valid;
    i_word_idx = (state == IFILL) ? recv_cnt : 3'd0;
    d_word_idx = (state == DFILL) ? recv_cnt : 3'd0;
    i_fill_done = state == IFILL && last_word;
    d_fill_done = state == DFILL && last_word;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed table and sequence checks of mem_arbiter against a 4-cycle memory
module tb_mem_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic i_miss = 1'b0, d_miss = 1'b0, d_wr_req = 1'b0;
  logic [15:0] i_miss_addr = '0, d_miss_addr = '0, d_wr_addr = '0, d_wr_data = '0;
  logic i_busy, i_data_valid, i_fill_done, d_busy, d_data_valid, d_fill_done, d_wr_ack;
  logic [2:0] i_word_idx, d_word_idx;
  logic mem_en, mem_wr, mem_data_valid;
  logic [15:0] mem_addr, mem_data_in;
  logic [3:0] pipe = '0;
  int checks = 0, failures = 0;
  bit wr_seen;

  typedef struct {
    logic im;
    logic [15:0] ia;
    logic en;
    logic [15:0] addr;
    logic iv;
    logic [2:0] idx;
    logic done;
    logic busy;
  } vec_t;
  vec_t tab[14];

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_miss(i_miss), .i_miss_addr(i_miss_addr), .i_busy(i_busy), .i_data_valid(i_data_valid),
    .i_word_idx(i_word_idx), .i_fill_done(i_fill_done),
    .d_miss(d_miss), .d_miss_addr(d_miss_addr), .d_busy(d_busy), .d_data_valid(d_data_valid),
    .d_word_idx(d_word_idx), .d_fill_done(d_fill_done),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data), .d_wr_ack(d_wr_ack),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_data_valid(mem_data_valid)
  );

  always #5 clk = ~clk;

  // memory model: a read issued in cycle N returns valid in cycle N+4; not reset with the DUT
  always @(posedge clk) pipe <= {pipe[2:0], mem_en && !mem_wr};
  assign mem_data_valid = pipe[3];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic all_zero(input string name);
    chk(name, 32'(|{mem_en, mem_wr, mem_addr, mem_data_in, i_busy, i_data_valid, i_word_idx, i_fill_done,
                    d_busy, d_data_valid, d_word_idx, d_fill_done, d_wr_ack}), 0);
  endtask

  task automatic wait_fill(input bit is_d, input string name);
    int n = 0;
    do begin
      tick();
      n++;
      if (mem_wr) wr_seen = 1'b1;
    end while (!(is_d ? d_fill_done : i_fill_done) && n < 40);
    chk({name, " fill_done"}, 32'(is_d ? d_fill_done : i_fill_done), 1);
  endtask

  initial begin
    int cnt, n, dv, mv;
    all_zero("reset async outputs");
    tick();
    tick();
    all_zero("reset held outputs");
    rst_n = 1'b1;
    for (int p = 0; p < 2; p++) begin
      for (int s = 0; s < 14; s++) begin
        tab[s].im = (p == 0) ? (s <= 11) : (s < 2);
        tab[s].ia = (p == 0 || s == 0) ? 16'h1234 : 16'hABCD;
        tab[s].en = s < 8;
        tab[s].addr = (s < 8) ? 16'(16'h1230 + 2 * s) : 16'h0000;
        tab[s].iv = s >= 4 && s <= 11;
        tab[s].idx = (s >= 4 && s <= 11) ? 3'(s - 4) : 3'd0;
        tab[s].done = s == 11;
        tab[s].busy = s <= 11;
      end
      for (int s = 0; s < 14; s++) begin
        i_miss = tab[s].im;
        i_miss_addr = tab[s].ia;
        tick();
        chk($sformatf("p%0d s%0d mem_en", p, s), 32'(mem_en), 32'(tab[s].en));
        chk($sformatf("p%0d s%0d mem_addr", p, s), 32'(mem_addr), 32'(tab[s].addr));
        chk($sformatf("p%0d s%0d i_data_valid", p, s), 32'(i_data_valid), 32'(tab[s].iv));
        chk($sformatf("p%0d s%0d i_word_idx", p, s), 32'(i_word_idx), 32'(tab[s].idx));
        chk($sformatf("p%0d s%0d i_fill_done", p, s), 32'(i_fill_done), 32'(tab[s].done));
        chk($sformatf("p%0d s%0d i_busy", p, s), 32'(i_busy), 32'(tab[s].busy));
        chk($sformatf("p%0d s%0d mem_wr", p, s), 32'(mem_wr), 0);
      end
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    i_miss = 1'b1; i_miss_addr = 16'h2000;
    d_miss = 1'b1; d_miss_addr = 16'h3000;
    tick();
    chk("both: D first d_busy", 32'(d_busy), 1);
    chk("both: D first i_busy", 32'(i_busy), 0);
    chk("both: D first addr", 32'(mem_addr), 32'h3000);
    wait_fill(1'b1, "both D1");
    tick();
    chk("both: gap idle", 32'({mem_en, i_busy, d_busy}), 0);
    tick();
    chk("both: I second i_busy", 32'(i_busy), 1);
    chk("both: I second addr", 32'(mem_addr), 32'h2000);
    wait_fill(1'b0, "both I");
    tick();
    chk("both: gap2 idle", 32'({mem_en, i_busy, d_busy}), 0);
    tick();
    chk("both: D third d_busy", 32'(d_busy), 1);
    chk("both: D third addr", 32'(mem_addr), 32'h3000);
    i_miss = 1'b0; d_miss = 1'b0;
    wait_fill(1'b1, "both D2");
    tick();
    tick();
    chk("both: final idle", 32'({mem_en, i_busy, d_busy}), 0);
    i_miss = 1'b1; i_miss_addr = 16'h1234;
    tick();
    chk("wr: I fill busy", 32'(i_busy), 1);
    tick();
    tick();
    d_wr_req = 1'b1; d_wr_addr = 16'h0100; d_wr_data = 16'hBEEF;
    wr_seen = 1'b0;
    wait_fill(1'b0, "wr I");
    chk("wr: no write during fill", 32'(wr_seen), 0);
    i_miss = 1'b0;
    tick();
    chk("wr: idle gap", 32'({mem_en, d_wr_ack}), 0);
    tick();
    chk("wr: mem_en", 32'(mem_en), 1);
    chk("wr: mem_wr", 32'(mem_wr), 1);
    chk("wr: mem_addr", 32'(mem_addr), 32'h0100);
    chk("wr: mem_data_in", 32'(mem_data_in), 32'hBEEF);
    chk("wr: ack", 32'(d_wr_ack), 1);
    chk("wr: d_busy", 32'(d_busy), 1);
    d_wr_req = 1'b0;
    tick();
    chk("wr: after ack", 32'({mem_en, d_wr_ack}), 0);
    d_miss = 1'b1; d_miss_addr = 16'h4447;
    d_wr_req = 1'b1; d_wr_addr = 16'h0200; d_wr_data = 16'h1111;
    tick();
    chk("wd: write first", 32'({mem_wr, d_wr_ack}), 32'h3);
    chk("wd: write addr", 32'(mem_addr), 32'h0200);
    chk("wd: write data", 32'(mem_data_in), 32'h1111);
    d_wr_req = 1'b0;
    tick();
    chk("wd: idle gap", 32'({mem_en, d_busy}), 0);
    tick();
    chk("wd: DFILL busy", 32'(d_busy), 1);
    chk("wd: DFILL addr", 32'(mem_addr), 32'h4440);
    chk("wd: DFILL read", 32'(mem_wr), 0);
    cnt = 0;
    n = 0;
    while (cnt < 3 && n < 40) begin
      tick();
      n++;
      if (d_data_valid) cnt++;
    end
    chk("rst: three words seen", 32'(cnt), 3);
    chk("rst: third word idx", 32'(d_word_idx), 2);
    rst_n = 1'b0;
    d_miss = 1'b0;
    #1;
    all_zero("rst: mid-fill outputs");
    tick();
    rst_n = 1'b1;
    dv = 0;
    mv = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (d_data_valid) dv++;
      if (mem_data_valid) mv++;
    end
    chk("rst: stale returns dropped", 32'(dv), 0);
    chk("rst: stale returns present", 32'(mv > 0), 1);
    d_miss = 1'b1; d_miss_addr = 16'h5550;
    tick();
    chk("rst: restart addr", 32'(mem_addr), 32'h5550);
    n = 0;
    while (!d_data_valid && n < 20) begin
      tick();
      n++;
    end
    chk("rst: restart first valid", 32'(d_data_valid), 1);
    chk("rst: restart word 0", 32'(d_word_idx), 0);
    wait_fill(1'b1, "rst restart");
    d_miss = 1'b0;
    tick();
    chk("rst: end idle", 32'({mem_en, d_busy}), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single shared main-memory port between the I-cache fill FSM, the D-cache fill FSM and the D-cache write-through path. Each fill grant issues eight consecutive word reads for one 16-byte block and steers the returning valid pulses to the owning cache. A write grant issues one word write. The block sits between the two caches and the 4-cycle pipelined memory model. Its grant and busy outputs drive the pipeline stall logic.

## Interface
Parameters:
- BLOCK_WORDS, 8: words per cache block; fixed, sets the 3-bit word counters.
- ADDR_W, 16: address and data width.

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_miss  in  1  I-cache miss request, level, held until i_fill_done.
- i_miss_addr  in  16  I-cache miss address.
- i_busy  out  1  fill in progress for I-cache.
- i_data_valid  out  1  returning word belongs to I-cache; write enable for the I data array.
- i_word_idx  out  3  word index of the returning I word.
- i_fill_done  out  1  one-cycle pulse with the 8th I word; tag/valid write enable.
- d_miss, d_miss_addr, d_busy, d_data_valid, d_word_idx, d_fill_done: D-cache equivalents of the I-cache ports.
- d_wr_req  in  1  D-cache write-through request, level.
- d_wr_addr  in  16  write address.
- d_wr_data  in  16  write data.
- d_wr_ack  out  1  one-cycle pulse in the cycle the write is issued.
- mem_en  out  1  memory enable.
- mem_wr  out  1  memory write enable.
- mem_addr  out  16  memory address.
- mem_data_in  out  16  memory write data.
- mem_data_valid  in  1  read data valid from memory; the data bus goes directly to both caches.

## Operation
- States: IDLE, IFILL, DFILL, DWRITE.
- Arbitration is evaluated in IDLE only, in priority order:
  - d_wr_req goes to DWRITE.
  - If both misses are pending, the requester not named by last_miss wins.
  - A single miss wins alone.
- last_miss is a 1-bit register, reset to I, and updated on every fill grant.
- On any grant, the arbiter latches base = addr[15:4] (or the full write address and data). Requester inputs are ignored after the grant.
- Fill, issue phase:
  - issue_cnt runs 0..7.
  - mem_en=1, mem_wr=0, mem_addr={base,issue_cnt,1'b0} for exactly 8 consecutive cycles starting the first cycle in the fill state.
  - The arbiter then holds mem_en=0.
- Fill, receive phase:
  - recv_cnt increments on each mem_data_valid.
  - Owner's data_valid = mem_data_valid; word_idx = recv_cnt.
  - When recv_cnt==7 and mem_data_valid, pulse the owner's fill_done, wrap both counters to 0, and go to IDLE.
- DWRITE lasts one cycle:
  - mem_en=1, mem_wr=1, mem_addr and mem_data_in from the latched write.
  - d_wr_ack=1 in that cycle, then IDLE.
- i_busy is 1 in IFILL; d_busy is 1 in DFILL or DWRITE.

## Timing
- Reset values: state IDLE, counters 0, last_miss=I. All outputs are 0; mem_addr and mem_data_in are 0.
- Request-to-first-issue latency is 1 cycle: request seen in IDLE at cycle N, first mem_en at N+1.
- Fill duration = 1 + 8 issue cycles, overlapping the return; the last valid arrives at issue 8 + memory latency.
- Back-to-back grants incur exactly one IDLE cycle between them.
- A request deasserted mid-fill does not abort the fill; the fill completes.
- mem_data_valid in IDLE or DWRITE is ignored: no data_valid is routed and counters hold.
- Reset mid-operation clears everything immediately. In-flight memory returns arrive in IDLE and are dropped. Requesters re-request.
- No combinational path from requests to mem_* outputs; all mem_* outputs decode from registered state and counters.

## Structure
- Package mem_arb_pkg holds:
  - state enum (IDLE, IFILL, DFILL, DWRITE)
  - BLOCK_WORDS and OFFSET_BITS=4
  - requester ID constants REQ_I and REQ_D
- Sub-module word_counter_3b: 3-bit counter with enable and synchronous clear, wrapping 7→0. It is instantiated twice, for issue and receive.

## Test plan
- I miss at 0x1234 → mem_addr sequence 0x1230,0x1232,…,0x123E on 8 consecutive cycles. i_word_idx 0..7 on returns. i_fill_done with the 8th valid. IDLE next cycle.
- i_miss and d_miss both rising in the cycle after reset → D filled first, then I after one IDLE cycle. Both held persistently → grants alternate D,I,D,I.
- d_wr_req at 0x0100, data 0xBEEF, during an I fill → no memory write until the fill completes. DWRITE one IDLE cycle after i_fill_done: mem_wr=1, addr 0x0100, data 0xBEEF, d_wr_ack=1.
- d_wr_req and d_miss together in IDLE → write first, then DFILL.
- rst_n low after the 3rd returned word of a D fill → all outputs 0 immediately. Later mem_data_valid pulses produce no d_data_valid. A new d_miss restarts at word 0.
- i_miss_addr changed and i_miss dropped mid-fill → addresses still use the latched base; fill runs to i_fill_done.
